// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// mem_stage : MEM pipeline stage - data-memory req/ack access, branch resolve,
//             EX forwarding values and the MEM/WB stage register.
//             Optional bus timeout enabled by defining MEM_TIMEOUT_EN.
// Revision  : 1.0
// ============================================================================
module mem_stage #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WB_EN,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic        MEM_TO_REG,
  input  logic        is_BRANCH,
  input  logic        zero,
  input  logic        TLB_MISS,
  input  logic        supervisor_mode,
  input  logic        WB_SYS_EN,
  input  logic [31:0] regDdata,
  input  logic [31:0] regBdata,
  input  logic [31:0] PCNEXT,
  input  logic [31:0] PC_TO_REG,
  input  logic [4:0]  regD,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        RegW_en_mem,
  output logic [4:0]  mem_regD,
  output logic [31:0] regFromMem,
  output logic        wb_en,
  output logic        wb_sys_en,
  output logic        wb_supervisor,
  output logic        wb_tlb_miss,
  output logic        wb_bus_err,
  output logic [4:0]  wb_regD,
  output logic [31:0] wb_data,
  output logic [31:0] wb_pc
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        timeout;
  logic        bus_err_q;
  logic        mem_op;

  logic        wb_en_q, wb_sys_en_q, wb_supervisor_q, wb_tlb_miss_q, wb_bus_err_q;
  logic [4:0]  wb_regD_q;
  logic [31:0] wb_data_q, wb_pc_q;

  assign mem_op = (MEM_R_EN | MEM_W_EN) & ~TLB_MISS;
  assign stall  = ((state_q == S_IDLE) & mem_op) | (state_q == S_WAIT);

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [CW-1:0] cnt_q;

  // Ack wins over timeout when both land on the last allowed WAIT cycle.
  assign timeout = (state_q == S_WAIT) & ~mem_ack & (cnt_q == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= ((state_q == S_WAIT) && (state_d == S_WAIT)) ? cnt_q + CW'(1) : '0;
      bus_err_q <= timeout;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = |TIMEOUT_CYCLES;
  assign timeout   = 1'b0;
  assign bus_err_q = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (mem_op) begin
          addr_d  = {regDdata[31:2], 2'b00};
          wdata_d = regBdata;
          we_d    = MEM_W_EN;
          req_d   = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_ack) begin
          if (!we_q) rdata_d = mem_rdata;
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_DONE;
        end else if (timeout) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // MEM/WB register: a stall inserts a bubble, data fields simply hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_en_q         <= 1'b0;
      wb_sys_en_q     <= 1'b0;
      wb_supervisor_q <= 1'b0;
      wb_tlb_miss_q   <= 1'b0;
      wb_bus_err_q    <= 1'b0;
      wb_regD_q       <= '0;
      wb_data_q       <= '0;
      wb_pc_q         <= '0;
    end else if (stall) begin
      wb_en_q         <= 1'b0;
      wb_sys_en_q     <= 1'b0;
      wb_tlb_miss_q   <= 1'b0;
      wb_bus_err_q    <= 1'b0;
    end else begin
      wb_en_q         <= WB_EN & ~TLB_MISS & ~bus_err_q;
      wb_sys_en_q     <= WB_SYS_EN & ~TLB_MISS;
      wb_supervisor_q <= supervisor_mode;
      wb_tlb_miss_q   <= TLB_MISS;
      wb_bus_err_q    <= bus_err_q;
      wb_regD_q       <= regD;
      wb_data_q       <= MEM_TO_REG ? rdata_q : regDdata;
      wb_pc_q         <= PC_TO_REG;
    end
  end

  assign mem_req       = req_q;
  assign mem_we        = we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign branch_taken  = is_BRANCH & zero;
  assign branch_target = PCNEXT;
  assign RegW_en_mem   = WB_EN & ~MEM_R_EN & ~TLB_MISS;
  assign mem_regD      = regD;
  assign regFromMem    = regDdata;
  assign wb_en         = wb_en_q;
  assign wb_sys_en     = wb_sys_en_q;
  assign wb_supervisor = wb_supervisor_q;
  assign wb_tlb_miss   = wb_tlb_miss_q;
  assign wb_bus_err    = wb_bus_err_q;
  assign wb_regD       = wb_regD_q;
  assign wb_data       = wb_data_q;
  assign wb_pc         = wb_pc_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// tb_mem_stage : directed scoreboard bench for mem_stage.
// Revision     : 1.0
// ============================================================================
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        WB_EN, MEM_R_EN, MEM_W_EN, MEM_TO_REG, is_BRANCH, zero;
  logic        TLB_MISS, supervisor_mode, WB_SYS_EN;
  logic [31:0] regDdata, regBdata, PCNEXT, PC_TO_REG;
  logic [4:0]  regD;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        stall, branch_taken, RegW_en_mem;
  logic [31:0] branch_target, regFromMem;
  logic [4:0]  mem_regD;
  logic        wb_en, wb_sys_en, wb_supervisor, wb_tlb_miss, wb_bus_err;
  logic [4:0]  wb_regD;
  logic [31:0] wb_data, wb_pc;

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN), .MEM_TO_REG(MEM_TO_REG),
    .is_BRANCH(is_BRANCH), .zero(zero), .TLB_MISS(TLB_MISS),
    .supervisor_mode(supervisor_mode), .WB_SYS_EN(WB_SYS_EN),
    .regDdata(regDdata), .regBdata(regBdata), .PCNEXT(PCNEXT), .PC_TO_REG(PC_TO_REG),
    .regD(regD),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .RegW_en_mem(RegW_en_mem), .mem_regD(mem_regD), .regFromMem(regFromMem),
    .wb_en(wb_en), .wb_sys_en(wb_sys_en), .wb_supervisor(wb_supervisor),
    .wb_tlb_miss(wb_tlb_miss), .wb_bus_err(wb_bus_err),
    .wb_regD(wb_regD), .wb_data(wb_data), .wb_pc(wb_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        en;
    logic [31:0] data;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        sys;
    logic        sup;
    logic        tlb;
    logic        berr;
  } wb_exp_t;

  wb_exp_t     sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  logic [31:0] last_rdata = 32'h0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic clear_ex();
    WB_EN = 0; MEM_R_EN = 0; MEM_W_EN = 0; MEM_TO_REG = 0; is_BRANCH = 0; zero = 0;
    TLB_MISS = 0; supervisor_mode = 0; WB_SYS_EN = 0;
    regDdata = 0; regBdata = 0; PCNEXT = 0; PC_TO_REG = 0; regD = 0;
  endtask

  task automatic check_wb(input string tag);
    wb_exp_t e;
    if (sb.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s:sb_empty observed=0 entries expected=1", tag);
    end else begin
      e = sb.pop_front();
      chk1({tag, ":wb_en"}, wb_en, e.en);
      chk({tag, ":wb_data"}, wb_data, e.data);
      chk({tag, ":wb_regD"}, {27'b0, wb_regD}, {27'b0, e.rd});
      chk({tag, ":wb_pc"}, wb_pc, e.pc);
      chk1({tag, ":wb_sys_en"}, wb_sys_en, e.sys);
      chk1({tag, ":wb_supervisor"}, wb_supervisor, e.sup);
      chk1({tag, ":wb_tlb_miss"}, wb_tlb_miss, e.tlb);
      chk1({tag, ":wb_bus_err"}, wb_bus_err, e.berr);
    end
  endtask

  // Memory op held in EX/MEM from cycle 0; ack in cycle k (or none -> timeout at k).
  task automatic run_mem(input string tag, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] rdata,
                         input logic [4:0] rd, input logic [31:0] pc, input logic wben,
                         input logic to_reg, input int k, input logic give_ack);
    wb_exp_t     e;
    logic [31:0] exp_addr;
    exp_addr = addr & 32'hFFFF_FFFC;
    for (int c = 0; c <= k + 1; c++) begin
      @(negedge clk);
      if (c == 0) begin
        clear_ex();
        MEM_R_EN = ~we; MEM_W_EN = we; regDdata = addr; regBdata = wdata;
        regD = rd; PC_TO_REG = pc; WB_EN = wben; MEM_TO_REG = to_reg;
        e.en   = wben & give_ack;
        e.data = to_reg ? ((give_ack && !we) ? rdata : last_rdata) : addr;
        e.rd   = rd; e.pc = pc; e.sys = 1'b0; e.sup = 1'b0; e.tlb = 1'b0;
        e.berr = ~give_ack;
        sb.push_back(e);
        if (give_ack && !we) last_rdata = rdata;
      end
      mem_ack   = give_ack && (c == k);
      mem_rdata = rdata;
      #1;
      chk1($sformatf("%s:mem_req_c%0d", tag, c), mem_req, (c >= 1 && c <= k));
      chk1($sformatf("%s:stall_c%0d", tag, c), stall, (c <= k));
      if (c >= 1 && c <= k) begin
        chk($sformatf("%s:mem_addr_c%0d", tag, c), mem_addr, exp_addr);
        chk1($sformatf("%s:mem_we_c%0d", tag, c), mem_we, we);
        if (we) chk($sformatf("%s:mem_wdata_c%0d", tag, c), mem_wdata, wdata);
      end
      if (c == k + 1) chk1($sformatf("%s:mem_we_done", tag), mem_we, 1'b0);
      if (c >= 1) chk1($sformatf("%s:bubble_c%0d", tag, c), wb_en, 1'b0);
    end
    @(negedge clk);
    clear_ex();
    mem_ack = 1'b0;
    #1;
    check_wb(tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    wb_exp_t e;
    reset = 1'b1;
    clear_ex();
    mem_ack = 1'b0;
    mem_rdata = 32'h0;

    @(negedge clk); #1;
    chk1("reset:mem_req", mem_req, 1'b0);
    chk1("reset:stall", stall, 1'b0);
    chk1("reset:mem_we", mem_we, 1'b0);
    chk("reset:mem_addr", mem_addr, 32'h0);
    chk1("reset:wb_en", wb_en, 1'b0);
    chk1("reset:wb_bus_err", wb_bus_err, 1'b0);
    chk("reset:wb_data", wb_data, 32'h0);
    chk("reset:wb_pc", wb_pc, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // ALU op: forwarded the same cycle, retired one edge later
    @(negedge clk);
    clear_ex();
    regDdata = 32'h1234; WB_EN = 1; regD = 5; PC_TO_REG = 32'h80;
    WB_SYS_EN = 1; supervisor_mode = 1;
    e.en = 1; e.data = 32'h1234; e.rd = 5; e.pc = 32'h80;
    e.sys = 1; e.sup = 1; e.tlb = 0; e.berr = 0;
    sb.push_back(e);
    #1;
    chk1("alu:RegW_en_mem", RegW_en_mem, 1'b1);
    chk("alu:regFromMem", regFromMem, 32'h1234);
    chk("alu:mem_regD", {27'b0, mem_regD}, 32'd5);
    chk1("alu:stall", stall, 1'b0);
    @(negedge clk);
    clear_ex();
    #1;
    check_wb("alu");
    chk1("alu:stall_after", stall, 1'b0);

    run_mem("load", 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 5'd7, 32'h84, 1'b1, 1'b1, 3, 1'b1);
    run_mem("store", 1'b1, 32'h203, 32'hCAFE, 32'h0BADF00D, 5'd2, 32'h88, 1'b0, 1'b0, 1, 1'b1);

    // Branch resolution
    @(negedge clk);
    clear_ex();
    is_BRANCH = 1; zero = 1; PCNEXT = 32'h40;
    #1;
    chk1("br:taken", branch_taken, 1'b1);
    chk("br:target", branch_target, 32'h40);
    @(negedge clk);
    zero = 0;
    #1;
    chk1("br:not_taken", branch_taken, 1'b0);

    // TLB-missed load: no access, no stall
    @(negedge clk);
    clear_ex();
    MEM_R_EN = 1; MEM_TO_REG = 1; WB_EN = 1; TLB_MISS = 1; WB_SYS_EN = 1;
    regDdata = 32'h300; regD = 9; PC_TO_REG = 32'h90;
    e.en = 0; e.data = last_rdata; e.rd = 9; e.pc = 32'h90;
    e.sys = 0; e.sup = 0; e.tlb = 1; e.berr = 0;
    sb.push_back(e);
    #1;
    chk1("tlb:stall", stall, 1'b0);
    chk1("tlb:RegW_en_mem", RegW_en_mem, 1'b0);
    @(negedge clk);
    clear_ex();
    #1;
    chk1("tlb:mem_req", mem_req, 1'b0);
    check_wb("tlb");

    // Reset in WAIT abandons the access
    @(negedge clk);
    clear_ex();
    MEM_R_EN = 1; WB_EN = 1; MEM_TO_REG = 1; regDdata = 32'h600; regD = 4;
    @(negedge clk); #1;
    chk1("rst_wait:mem_req_before", mem_req, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk1("rst_wait:mem_req_async", mem_req, 1'b0);
    chk1("rst_wait:wb_en", wb_en, 1'b0);
    sb.delete();
    last_rdata = 32'h0;
    @(negedge clk);
    reset = 1'b0;
    clear_ex();
    mem_ack = 1'b1;
    mem_rdata = 32'hFFFF0000;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk1("rst_wait:late_ack_req", mem_req, 1'b0);
    chk1("rst_wait:late_ack_stall", stall, 1'b0);
    chk("rst_wait:rdata_cleared_wb", wb_data, 32'h0);

    run_mem("reload", 1'b0, 32'h404, 32'h0, 32'h13579BDF, 5'd3, 32'hA0, 1'b1, 1'b1, 2, 1'b1);

`ifdef MEM_TIMEOUT_EN
    run_mem("timeout", 1'b0, 32'h500, 32'h0, 32'h0, 5'd6, 32'hB0, 1'b1, 1'b1, 4, 1'b0);
    @(negedge clk);
    mem_ack = 1'b1;
    mem_rdata = 32'h55AA55AA;
    @(negedge clk);
    mem_ack = 1'b0;
    #1;
    chk1("timeout:late_ack_req", mem_req, 1'b0);
    chk1("timeout:late_ack_stall", stall, 1'b0);
    chk1("timeout:late_ack_wb_en", wb_en, 1'b0);
    chk1("timeout:late_ack_berr", wb_bus_err, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
